// File: rtl/fifo_digit_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_digit_display_if                                           |
// | Brief    : FIFO read-port bundle between the RX FIFO and its consumer.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fifo_digit_display_if;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;

    modport master (output rdata, output rempty, input rinc);
    modport slave  (input rdata, input rempty, output rinc);
endinterface
`default_nettype wire

// File: rtl/fifo_digit_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_digit_display                                              |
// | Brief    : Pops RX FIFO bytes into a DIGITS-deep decimal buffer and scans  |
// |            it onto an active-low multiplexed 7-segment display.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fifo_digit_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 27000
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_digit_display_if.slave           rd,
    output logic [6:0]                    sseg,
    output logic [DIGITS-1:0]             an,
    output logic                          drop_pulse,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count
);
    localparam int CNT_W  = $clog2(DIGITS+1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [3:0]        C_BLANK     = 4'hF;
    localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(DIGITS);
    localparam logic [SCAN_W-1:0] C_SCAN_LAST = SCAN_W'(SCAN_DIV-1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(DIGITS-1);
    localparam logic [DIGITS-1:0] C_ONE       = DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_char;
    logic [3:0]        r_buf [DIGITS];
    logic [SCAN_W-1:0] r_scan;
    logic [IDX_W-1:0]  r_idx;

    logic              w_is_digit;
    logic              w_is_bs;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg;

    assign w_is_digit = (r_char >= 8'h30) && (r_char <= 8'h39);
    assign w_is_bs    = (r_char == 8'h08) || (r_char == 8'h7F);
    // ASCII '0'..'9' carry their value in the low nibble
    assign w_digit    = r_char[3:0];

    // Read FSM: IDLE latches the byte, POP arms the strobe, APPLY acts on it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_char      <= 8'h00;
            rd.rinc     <= 1'b0;
            drop_pulse  <= 1'b0;
            digit_count <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                r_buf[i] <= C_BLANK;
            end
        end else begin
            rd.rinc    <= 1'b0;
            drop_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!rd.rempty) begin
                        r_char  <= rd.rdata;
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    rd.rinc <= 1'b1;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                    if (w_is_digit) begin
                        for (int i = DIGITS-1; i > 0; i--) begin
                            r_buf[i] <= r_buf[i-1];
                        end
                        r_buf[0] <= w_digit;
                        if (digit_count != C_FULL) begin
                            digit_count <= digit_count + 1'b1;
                        end
                    end else if (w_is_bs) begin
                        // Backspace on an empty buffer is a silent no-op
                        if (digit_count != '0) begin
                            for (int i = 0; i < DIGITS-1; i++) begin
                                r_buf[i] <= r_buf[i+1];
                            end
                            r_buf[DIGITS-1] <= C_BLANK;
                            digit_count     <= digit_count - 1'b1;
                        end
                    end else if (r_char == 8'h1B) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            r_buf[i] <= C_BLANK;
                        end
                        digit_count <= '0;
                    end else if (r_char != 8'h00) begin
                        drop_pulse <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_seg = 7'b1111111;
        case (r_buf[r_idx])
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
    end

    // Scan: each position held for SCAN_DIV cycles; outputs lag the index by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= '0;
            sseg   <= 7'b1111111;
            an     <= ~C_ONE;
        end else begin
            if (r_scan == C_SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            sseg <= w_seg;
            an   <= ~(C_ONE << r_idx);
        end
    end
endmodule
`default_nettype wire
